// File: rtl/stream_mux_nx1_if.sv
// stream_mux_nx1_if: input channels, consumer handshake and control for stream_mux_nx1.
// The mux connects through the slave modport; producers and consumer use the master modport.
interface stream_mux_nx1_if #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8,
  parameter int SEL_W = $clog2(N_CH)
);
  logic                    mode;
  logic [SEL_W-1:0]        sel;
  logic [N_CH*WIDTH-1:0]   in_data;
  logic [N_CH-1:0]         in_valid;
  logic [N_CH-1:0]         in_last;
  logic [N_CH-1:0]         in_ready;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic                    out_last;
  logic [SEL_W-1:0]        out_ch;
  logic                    out_ready;

  modport master (
    output mode, sel, in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid, out_last, out_ch
  );

  modport slave (
    input  mode, sel, in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid, out_last, out_ch
  );
endinterface

// File: rtl/stream_mux_nx1.sv
// stream_mux_nx1: N-channel valid/ready stream mux, fixed-select or round-robin grant, one-entry output register.
// Define STREAM_MUX_LOCK_EN to keep a grant on one channel until it delivers a beat with in_last set.
module stream_mux_nx1 #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8,
  parameter int SEL_W = $clog2(N_CH)
) (
  input logic             clk,
  input logic             rst_n,
  stream_mux_nx1_if.slave bus
);
  localparam logic [SEL_W:0]   N_CH_L    = (SEL_W+1)'(N_CH);
  localparam logic [SEL_W-1:0] LAST_CH_L = SEL_W'(N_CH - 1);

  logic [WIDTH-1:0] out_data_r;
  logic             out_valid_r;
  logic             out_last_r;
  logic [SEL_W-1:0] out_ch_r;
  logic [SEL_W-1:0] last_grant_r;

  logic             load_ok_s;
  logic             rr_vld_s;
  logic [SEL_W-1:0] rr_ch_s;
  int               rr_dist_s;
  int               rr_best_s;
  logic             rr_hit_s;
  logic             cand_vld_s;
  logic [SEL_W-1:0] cand_s;
  logic [N_CH-1:0]  in_ready_s;
  logic             xfer_s;
  logic [WIDTH-1:0] sel_data_s;
  logic             sel_last_s;

`ifdef STREAM_MUX_LOCK_EN
  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_state_t;
  lock_state_t      lock_state_r;
  logic [SEL_W-1:0] lock_ch_r;
`endif

  assign load_ok_s = !out_valid_r || bus.out_ready;

  // Round-robin pick: valid channel at the smallest circular distance above last_grant.
  always_comb begin
    rr_vld_s  = 1'b0;
    rr_ch_s   = '0;
    rr_best_s = N_CH;
    rr_dist_s = 0;
    rr_hit_s  = 1'b0;
    for (int j = 0; j < N_CH; j++) begin
      rr_dist_s = (j > int'(last_grant_r)) ? (j - int'(last_grant_r) - 1)
                                           : (j - int'(last_grant_r) - 1 + N_CH);
      rr_hit_s  = bus.in_valid[j] && (rr_dist_s < rr_best_s);
      rr_best_s = rr_hit_s ? rr_dist_s : rr_best_s;
      rr_ch_s   = rr_hit_s ? SEL_W'(j) : rr_ch_s;
      rr_vld_s  = rr_vld_s || rr_hit_s;
    end
  end

  // Candidate channel; a held lock overrides both modes, and an out-of-range sel grants nobody.
  always_comb begin
    cand_s     = '0;
    cand_vld_s = 1'b0;
`ifdef STREAM_MUX_LOCK_EN
    if (lock_state_r == LOCKED) begin
      cand_s     = lock_ch_r;
      cand_vld_s = 1'b1;
    end else
`endif
    if (bus.mode) begin
      cand_s     = rr_ch_s;
      cand_vld_s = rr_vld_s;
    end else begin
      cand_s     = bus.sel;
      cand_vld_s = ({1'b0, bus.sel} < N_CH_L);
    end
  end

  // One-hot ready plus the beat offered by the granted channel.
  always_comb begin
    in_ready_s = '0;
    xfer_s     = 1'b0;
    sel_data_s = '0;
    sel_last_s = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      in_ready_s[i] = load_ok_s && cand_vld_s && (cand_s == SEL_W'(i));
      xfer_s        = xfer_s || (in_ready_s[i] && bus.in_valid[i]);
      sel_data_s    = in_ready_s[i] ? bus.in_data[i*WIDTH +: WIDTH] : sel_data_s;
      sel_last_s    = in_ready_s[i] ? bus.in_last[i] : sel_last_s;
    end
  end

  // Output register, grant pointer and packet-lock state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_r   <= '0;
      out_valid_r  <= 1'b0;
      out_last_r   <= 1'b0;
      out_ch_r     <= '0;
      last_grant_r <= LAST_CH_L;
`ifdef STREAM_MUX_LOCK_EN
      lock_state_r <= UNLOCKED;
      lock_ch_r    <= '0;
`endif
    end else begin
      if (load_ok_s) begin
        out_valid_r <= xfer_s;
        if (xfer_s) begin
          out_data_r <= sel_data_s;
          out_last_r <= sel_last_s;
          out_ch_r   <= cand_s;
        end
      end
      if (xfer_s) begin
`ifdef STREAM_MUX_LOCK_EN
        // The pointer only moves when the grant is released, so a locked packet keeps its turn.
        case (lock_state_r)
          UNLOCKED: begin
            if (!sel_last_s) begin
              lock_state_r <= LOCKED;
              lock_ch_r    <= cand_s;
            end else begin
              last_grant_r <= cand_s;
            end
          end
          LOCKED: begin
            if (sel_last_s) begin
              lock_state_r <= UNLOCKED;
              last_grant_r <= cand_s;
            end
          end
          default: lock_state_r <= UNLOCKED;
        endcase
`else
        last_grant_r <= cand_s;
`endif
      end
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_data  = out_data_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_last  = out_last_r;
  assign bus.out_ch    = out_ch_r;

endmodule

// File: tb/tb_stream_mux_nx1.sv
// tb_stream_mux_nx1: table-driven cycle vectors for select/round-robin/backpressure/out-of-range sel,
// followed by hand sequences for reset while holding a beat and packet locking (both builds).
module tb_stream_mux_nx1;
  localparam int N_CH  = 4;
  localparam int WIDTH = 8;
  localparam int SEL_W = 3;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  stream_mux_nx1_if #(.N_CH(N_CH), .WIDTH(WIDTH), .SEL_W(SEL_W)) bus ();

  stream_mux_nx1 #(.N_CH(N_CH), .WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       mode;
    logic [2:0] sel;
    logic [3:0] valid;
    logic       ordy;
    logic [3:0] exp_rdy;
    logic       exp_ov;
    logic [2:0] exp_ch;
    logic [7:0] exp_data;
    logic       exp_last;
  } vec_t;

  vec_t tbl [18];

  logic [2:0] lk_ch   [6];
  logic [7:0] lk_data [6];
  logic       lk_last [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b0;
    int b1;
    int n_out;
    n_cmp = 0;
    n_err = 0;

    // Channel data: ch0=11, ch1=22, ch2=A5, ch3=44; every table beat carries last=1.
    //            mode  sel   valid    ordy  exp_rdy  ov    ch    data   last
    tbl[0]  = '{1'b0, 3'd2, 4'b1111, 1'b1, 4'b0100, 1'b0, 3'd0, 8'h00, 1'b0};
    tbl[1]  = '{1'b0, 3'd2, 4'b0000, 1'b1, 4'b0100, 1'b1, 3'd2, 8'hA5, 1'b1};
    tbl[2]  = '{1'b1, 3'd2, 4'b1111, 1'b1, 4'b1000, 1'b0, 3'd2, 8'hA5, 1'b1};
    tbl[3]  = '{1'b1, 3'd2, 4'b1111, 1'b1, 4'b0001, 1'b1, 3'd3, 8'h44, 1'b1};
    tbl[4]  = '{1'b1, 3'd2, 4'b1111, 1'b1, 4'b0010, 1'b1, 3'd0, 8'h11, 1'b1};
    tbl[5]  = '{1'b1, 3'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 3'd1, 8'h22, 1'b1};
    tbl[6]  = '{1'b1, 3'd2, 4'b1111, 1'b1, 4'b1000, 1'b1, 3'd2, 8'hA5, 1'b1};
    tbl[7]  = '{1'b1, 3'd2, 4'b1111, 1'b1, 4'b0001, 1'b1, 3'd3, 8'h44, 1'b1};
    tbl[8]  = '{1'b1, 3'd2, 4'b1010, 1'b1, 4'b0010, 1'b1, 3'd0, 8'h11, 1'b1};
    tbl[9]  = '{1'b1, 3'd2, 4'b1010, 1'b0, 4'b0000, 1'b1, 3'd1, 8'h22, 1'b1};
    tbl[10] = '{1'b1, 3'd2, 4'b1010, 1'b0, 4'b0000, 1'b1, 3'd1, 8'h22, 1'b1};
    tbl[11] = '{1'b1, 3'd2, 4'b1010, 1'b1, 4'b1000, 1'b1, 3'd1, 8'h22, 1'b1};
    tbl[12] = '{1'b1, 3'd2, 4'b1010, 1'b1, 4'b0010, 1'b1, 3'd3, 8'h44, 1'b1};
    tbl[13] = '{1'b1, 3'd2, 4'b0000, 1'b0, 4'b0000, 1'b1, 3'd1, 8'h22, 1'b1};
    tbl[14] = '{1'b0, 3'd4, 4'b1111, 1'b1, 4'b0000, 1'b1, 3'd1, 8'h22, 1'b1};
    tbl[15] = '{1'b0, 3'd4, 4'b1111, 1'b1, 4'b0000, 1'b0, 3'd1, 8'h22, 1'b1};
    tbl[16] = '{1'b0, 3'd3, 4'b1111, 1'b0, 4'b1000, 1'b0, 3'd1, 8'h22, 1'b1};
    tbl[17] = '{1'b0, 3'd1, 4'b0000, 1'b0, 4'b0000, 1'b1, 3'd3, 8'h44, 1'b1};

    // Expected output beats for ch0 sending last=0,0,1 while ch1 is always valid.
`ifdef STREAM_MUX_LOCK_EN
    lk_ch   = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1};
    lk_data = '{8'hC0, 8'hC1, 8'hC2, 8'hD0, 8'hD1, 8'hD2};
    lk_last = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
`else
    lk_ch   = '{3'd0, 3'd1, 3'd0, 3'd1, 3'd0, 3'd1};
    lk_data = '{8'hC0, 8'hD0, 8'hC1, 8'hD1, 8'hC2, 8'hD2};
    lk_last = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
`endif

    rst_n         = 1'b0;
    bus.mode      = 1'b0;
    bus.sel       = 3'd0;
    bus.in_data   = {8'h44, 8'hA5, 8'h22, 8'h11};
    bus.in_valid  = 4'b0000;
    bus.in_last   = 4'b1111;
    bus.out_ready = 1'b0;

    #12;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data",  32'(bus.out_data),  32'd0);
    chk("rst_out_ch",    32'(bus.out_ch),    32'd0);
    chk("rst_out_last",  32'(bus.out_last),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 18; v++) begin
      @(posedge clk);
      #1;
      bus.mode      = tbl[v].mode;
      bus.sel       = tbl[v].sel;
      bus.in_valid  = tbl[v].valid;
      bus.out_ready = tbl[v].ordy;
      @(negedge clk);
      chk($sformatf("v%0d_in_ready", v),  32'(bus.in_ready),  32'(tbl[v].exp_rdy));
      chk($sformatf("v%0d_out_valid", v), 32'(bus.out_valid), 32'(tbl[v].exp_ov));
      chk($sformatf("v%0d_out_ch", v),    32'(bus.out_ch),    32'(tbl[v].exp_ch));
      chk($sformatf("v%0d_out_data", v),  32'(bus.out_data),  32'(tbl[v].exp_data));
      chk($sformatf("v%0d_out_last", v),  32'(bus.out_last),  32'(tbl[v].exp_last));
    end

    // Reset asserted mid-cycle while a beat is held under backpressure.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_out_data",  32'(bus.out_data),  32'd0);
    chk("midrst_out_ch",    32'(bus.out_ch),    32'd0);
    bus.in_valid  = 4'b0000;
    bus.mode      = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    // Packet sequence: ch0 has three beats, ch1 streams single-beat packets.
    b0    = 0;
    b1    = 0;
    n_out = 0;
    for (int c = 0; c < 7; c++) begin
      @(posedge clk);
      #1;
      bus.in_valid = {2'b00, 1'b1, (b0 < 3)};
      bus.in_data  = {8'h00, 8'h00, 8'hD0 + 8'(b1), 8'hC0 + 8'(b0)};
      bus.in_last  = {2'b00, 1'b1, (b0 == 2)};
      @(negedge clk);
      if (bus.out_valid) begin
        if (n_out < 6) begin
          chk($sformatf("pkt%0d_out_ch", n_out),   32'(bus.out_ch),   32'(lk_ch[n_out]));
          chk($sformatf("pkt%0d_out_data", n_out), 32'(bus.out_data), 32'(lk_data[n_out]));
          chk($sformatf("pkt%0d_out_last", n_out), 32'(bus.out_last), 32'(lk_last[n_out]));
        end
        n_out++;
      end
      if (bus.in_valid[0] && bus.in_ready[0]) b0++;
      if (bus.in_valid[1] && bus.in_ready[1]) b1++;
    end
    chk("pkt_beat_count", 32'(n_out), 32'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/stream_mux_nx1.md
# stream_mux_nx1

Parametrised N-channel, WIDTH-bit stream multiplexer with valid/ready handshaking and a registered output stage. It succeeds the single-bit 2:1 select mux as the team's general channel-merge block. It sits between several producer streams and one consumer. It supports two modes: a fixed select, which behaves like the classic mux, and fair round-robin arbitration.

## Interface
- N_CH, 4, number of input channels (2..16)
- WIDTH, 8, data bits per channel
- SEL_W, $clog2(N_CH), width of channel index (derived, not overridden)

- clk  input  1  single clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- mode  input  1  0 = fixed select via sel, 1 = round-robin
- sel  input  SEL_W  channel index used when mode=0
- in_data  input  N_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  N_CH  per-channel valid
- in_last  input  N_CH  per-channel end-of-packet marker
- in_ready  output  N_CH  per-channel ready (combinational)
- out_data  output  WIDTH  registered output data
- out_valid  output  1  registered output valid
- out_last  output  1  registered copy of accepted in_last
- out_ch  output  SEL_W  index of channel that supplied the current output beat
- out_ready  input  1  consumer ready

## Operation
- Output stage: one-entry register. It can load when `load_ok = !out_valid || out_ready`.
- Grant selection, combinational, evaluated every cycle:
  - mode=0: candidate = sel. If sel >= N_CH, there is no candidate.
  - mode=1: candidate = first channel with in_valid=1, searching upward circularly from last_grant+1 and wrapping at N_CH-1 -> 0.
- in_ready[i] = load_ok && (candidate == i). At most one bit of in_ready is set. Channels that are not candidates see in_ready=0.
- Transfer on channel i when in_valid[i] && in_ready[i]:
  - out_data/out_last/out_ch load that channel's beat.
  - out_valid <= 1.
  - last_grant <= i. last_grant updates in both modes.
- If load_ok and there is no transfer, out_valid <= 0 on the next edge. out_data keeps its last value.
- The held beat never changes while out_valid && !out_ready.
- mode or sel changes take effect on the next grant evaluation. They never alter a beat already held.
- in_last is ignored unless STREAM_MUX_LOCK_EN is defined.

## Timing
- Latency: 1 cycle from input transfer to out_valid=1.
- Throughput: 1 beat/cycle when out_ready is held high, including back-to-back beats from different channels.
- in_ready depends combinationally on out_ready, in_valid, mode, sel and lock state. There is no combinational path from inputs to out_*.
- Reset (asynchronous assert, synchronous-safe deassert):
  - out_valid=0, out_data=0, out_last=0, out_ch=0.
  - last_grant=N_CH-1, so channel 0 has first priority.
  - Lock state = UNLOCKED.
- Reset mid-operation discards the held beat. No partial transfer occurs.
- Simultaneous out_ready and a new input transfer: the old beat is consumed and the new beat is loaded on the same edge.

## Configuration
- Macro: STREAM_MUX_LOCK_EN.
- Defined: a two-state FSM with states UNLOCKED and LOCKED(ch).
  - UNLOCKED -> LOCKED(i) on a transfer from channel i with in_last[i]=0.
  - LOCKED(i) -> UNLOCKED on a transfer from channel i with in_last[i]=1.
  - While LOCKED, candidate = i regardless of mode, sel and other valids. Other channels stay stalled.
  - A transfer with in_last=1 taken while UNLOCKED leaves the FSM UNLOCKED.
  - The round-robin pointer advances only on transitions into UNLOCKED.
- Undefined: no FSM is built and every beat is arbitrated independently. in_last is still registered into out_last.

## Test plan
- Reset, then mode=0, sel=2, in_valid=4'b1111, ch2 data=8'hA5, out_ready=1 -> only in_ready[2]=1; the next cycle gives out_data=8'hA5, out_ch=2, out_valid=1.
- mode=1, all four channels valid continuously, out_ready=1 -> out_ch sequence is 0,1,2,3,0,… with one beat per cycle and no gaps.
- mode=1, only ch1 and ch3 valid, out_ready toggling 1,0,1 -> the held beat is stable while out_ready=0, the order is 1,3,1, and no beat is lost or duplicated.
- mode=0, sel=N_CH (out of range, N_CH=4 with SEL_W=3 override test build) -> in_ready=0 on all channels and out_valid falls to 0 after the held beat drains.
- With STREAM_MUX_LOCK_EN: ch0 sends 3 beats with last=0,0,1 while ch1 is valid throughout -> out_ch=0,0,0 then 1. Without the macro, the same stimulus in mode=1 gives 0,1,0,1,…
- Assert rst_n=0 while out_valid=1 and out_ready=0 -> out_valid=0 and out_data=0 immediately, and after release ch0 has priority.
